// File: rtl/legv8_hazard_unit.sv
`default_nettype none
//==============================================================================
// legv8_hazard_unit : stall/flush/forwarding control with a shadow EX/MEM/WB scoreboard
// Revision 1.0
//==============================================================================
module legv8_hazard_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int ZERO_REG   = 31,
   parameter int FWD_EN     = 1,
   parameter int CNT_W      = 32
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic                  id_rs1_used,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  branch_taken,
   output logic                  stall,
   output logic                  flush_ifid,
   output logic                  flush_idex,
   output logic                  flush_exmem,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  id_byp_a,
   output logic                  id_byp_b,
   output logic [CNT_W-1:0]      stall_count,
   output logic [CNT_W-1:0]      flush_count
);

   localparam logic [REG_ADDR_W-1:0] c_ZERO_REG = REG_ADDR_W'(ZERO_REG);
   localparam logic [1:0]            c_SEL_RF   = 2'b00;
   localparam logic [1:0]            c_SEL_WB   = 2'b01;
   localparam logic [1:0]            c_SEL_MEM  = 2'b10;
   localparam logic [CNT_W-1:0]      c_CNT_MAX  = {CNT_W{1'b1}};

   logic                  r_exValid, r_exRs1Used, r_exRs2Used, r_exRegWrite, r_exMemRead;
   logic [REG_ADDR_W-1:0] r_exRd, r_exRs1, r_exRs2;
   logic                  r_memValid, r_memRegWrite;
   logic [REG_ADDR_W-1:0] r_memRd;
   logic                  r_wbValid, r_wbRegWrite;
   logic [REG_ADDR_W-1:0] r_wbRd;
   logic [CNT_W-1:0]      r_stallCount, r_flushCount;

   logic                  w_exHitId, w_memHitId, w_stallRaw;
   logic [1:0]            w_fwdA, w_fwdB;

   // True when a live producer writes a source the consumer actually reads (XZR excluded).
   function automatic logic writesReg(input logic valid, input logic regWrite,
                                      input logic [REG_ADDR_W-1:0] rd,
                                      input logic [REG_ADDR_W-1:0] r, input logic used);
      return used & valid & regWrite & (rd == r) & (r != c_ZERO_REG);
   endfunction

   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         r_exValid  <= 1'b0;
         r_memValid <= 1'b0;
         r_wbValid  <= 1'b0;
      end else begin
         r_wbValid  <= r_memValid;
         r_memValid <= r_exValid & ~branch_taken;
         r_exValid  <= id_valid & ~stall & ~branch_taken;
      end
   end

   always_ff @(posedge CLOCK) begin
      r_wbRd        <= r_memRd;
      r_wbRegWrite  <= r_memRegWrite;
      r_memRd       <= r_exRd;
      r_memRegWrite <= r_exRegWrite;
      r_exRd        <= id_rd;
      r_exRs1       <= id_rs1;
      r_exRs1Used   <= id_rs1_used;
      r_exRs2       <= id_rs2;
      r_exRs2Used   <= id_rs2_used;
      r_exRegWrite  <= id_reg_write;
      r_exMemRead   <= id_mem_read;
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         r_stallCount <= '0;
         r_flushCount <= '0;
      end else begin
         if (stall && (r_stallCount != c_CNT_MAX))
            r_stallCount <= r_stallCount + 1'b1;
         if (branch_taken && (r_flushCount != c_CNT_MAX))
            r_flushCount <= r_flushCount + 1'b1;
      end
   end

   assign w_exHitId  = id_valid &
                       (writesReg(r_exValid, r_exRegWrite, r_exRd, id_rs1, id_rs1_used) |
                        writesReg(r_exValid, r_exRegWrite, r_exRd, id_rs2, id_rs2_used));
   assign w_memHitId = id_valid &
                       (writesReg(r_memValid, r_memRegWrite, r_memRd, id_rs1, id_rs1_used) |
                        writesReg(r_memValid, r_memRegWrite, r_memRd, id_rs2, id_rs2_used));

   // Without forwarding every EX/MEM producer interlocks; WB is covered by the ID bypass.
   assign w_stallRaw = (FWD_EN != 0) ? (w_exHitId & r_exMemRead)
                                     : (w_exHitId | w_memHitId);

   // MEM is checked first: it holds the youngest producer.
   always_comb begin
      w_fwdA = c_SEL_RF;
      w_fwdB = c_SEL_RF;
      if (r_exValid) begin
         if (writesReg(r_memValid, r_memRegWrite, r_memRd, r_exRs1, r_exRs1Used))
            w_fwdA = c_SEL_MEM;
         else if (writesReg(r_wbValid, r_wbRegWrite, r_wbRd, r_exRs1, r_exRs1Used))
            w_fwdA = c_SEL_WB;
         if (writesReg(r_memValid, r_memRegWrite, r_memRd, r_exRs2, r_exRs2Used))
            w_fwdB = c_SEL_MEM;
         else if (writesReg(r_wbValid, r_wbRegWrite, r_wbRd, r_exRs2, r_exRs2Used))
            w_fwdB = c_SEL_WB;
      end
   end

   assign stall       = w_stallRaw & ~branch_taken;
   assign flush_ifid  = branch_taken;
   assign flush_idex  = branch_taken;
   assign flush_exmem = branch_taken;
   assign fwd_a       = (FWD_EN != 0) ? w_fwdA : c_SEL_RF;
   assign fwd_b       = (FWD_EN != 0) ? w_fwdB : c_SEL_RF;
   assign id_byp_a    = id_valid & writesReg(r_wbValid, r_wbRegWrite, r_wbRd, id_rs1, id_rs1_used);
   assign id_byp_b    = id_valid & writesReg(r_wbValid, r_wbRegWrite, r_wbRd, id_rs2, id_rs2_used);
   assign stall_count = r_stallCount;
   assign flush_count = r_flushCount;

endmodule
`default_nettype wire
